// File: rtl/cpu_pkg.sv
// Shared types and constants for the program-counter sequencer of the single-cycle core.
package cpu_pkg;
  localparam int PC_W        = 64;
  localparam int INSTR_BYTES = 4;
  localparam logic [PC_W-1:0] DEFAULT_RESET_VEC = 64'h0;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_t;

  // Instructions are word-sized, so any fetch address must have its two low bits clear.
  function automatic logic is_aligned(input logic [PC_W-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction
endpackage

// File: rtl/branch_target_gen.sv
// Combinational next-PC selection: sequential step, PC-relative branch or register target.
module branch_target_gen
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0] i_pc,
  input  logic [PC_W-1:0] i_imm,
  input  logic [PC_W-1:0] i_reg_target,
  input  logic            i_cond_br,
  input  logic            i_zero,
  input  logic            i_uncond_br,
  input  logic            i_reg_br,
  output logic [PC_W-1:0] o_target,
  output logic            o_taken
);
  logic [PC_W-1:0] w_seq;
  logic [PC_W-1:0] w_rel;

  // Both sums wrap modulo 2^64; the offset counts words, hence the shift.
  assign w_seq = i_pc + PC_W'(INSTR_BYTES);
  assign w_rel = i_pc + (i_imm << 2);

  always_comb begin
    o_target = w_seq;
    o_taken  = 1'b1;
    if (i_reg_br)                   o_target = i_reg_target;
    else if (i_uncond_br)           o_target = w_rel;
    else if (i_cond_br && i_zero)   o_target = w_rel;
    else                            o_taken  = 1'b0;
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program counter register with BOOT/RUN/HALT/FAULT control, misaligned-target trap and taken-branch counter.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_VEC = cpu_pkg::DEFAULT_RESET_VEC,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic             halt_i,
  input  logic             resume_i,
  input  logic             cond_br_i,
  input  logic             zero_i,
  input  logic             uncond_br_i,
  input  logic             reg_br_i,
  input  logic [63:0]      imm_i,
  input  logic [63:0]      reg_target_i,
  input  logic             fault_clr_i,
  output logic [63:0]      pc_o,
  output logic [63:0]      pc_next_o,
  output logic             pc_valid_o,
  output logic             fault_o,
  output logic [63:0]      fault_addr_o,
  output logic [CNT_W-1:0] taken_cnt_o,
  output state_t           state_o
);
  state_t           r_state;
  logic [63:0]      r_pc;
  logic             r_valid;
  logic             r_fault;
  logic [63:0]      r_fault_addr;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      w_target;
  logic             w_taken;

  branch_target_gen u_btg (
    .i_pc         (r_pc),
    .i_imm        (imm_i),
    .i_reg_target (reg_target_i),
    .i_cond_br    (cond_br_i),
    .i_zero       (zero_i),
    .i_uncond_br  (uncond_br_i),
    .i_reg_br     (reg_br_i),
    .o_target     (w_target),
    .o_taken      (w_taken)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= BOOT;
      r_pc         <= RESET_VEC;
      r_valid      <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        BOOT: begin
          r_state <= RUN;
          r_valid <= 1'b1;
        end
        RUN: begin
          if (en_i) begin
            if (!is_aligned(w_target)) begin
              r_fault      <= 1'b1;
              r_fault_addr <= w_target;
              r_state      <= FAULT;
              r_valid      <= 1'b0;
            end else begin
              r_pc <= w_target;
              if (w_taken) r_cnt <= r_cnt + CNT_W'(1);
              // The current instruction's branch still commits before fetching stops.
              if (halt_i) begin
                r_state <= HALT;
                r_valid <= 1'b0;
              end
            end
          end
        end
        HALT: begin
          if (resume_i) begin
            r_state <= RUN;
            r_valid <= 1'b1;
          end
        end
        FAULT: begin
          if (fault_clr_i) begin
            r_fault <= 1'b0;
            r_state <= RUN;
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= BOOT;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o         = r_pc;
  assign pc_next_o    = w_target;
  assign pc_valid_o   = r_valid;
  assign fault_o      = r_fault;
  assign fault_addr_o = r_fault_addr;
  assign taken_cnt_o  = r_cnt;
  assign state_o      = r_state;
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the 64-bit program counter of the single-cycle core.
- Each cycle it chooses the next PC: sequential PC+4, PC-relative branch (branch-adder path: PC + offset*4) or register-indirect branch. It commits the choice on the clock edge.
- Adds stall, halt and misaligned-target fault control, plus a counter of taken branches.
- Sits between the control unit / ALU flags and instruction memory.

Parameters:
- RESET_VEC, 64'h0, PC value loaded on reset.
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- en_i  in  1  advance enable; 0 = stall, PC holds.
- halt_i  in  1  request to stop fetching after the current instruction.
- resume_i  in  1  leave HALT.
- cond_br_i  in  1  conditional branch instruction (CBZ-type).
- zero_i  in  1  ALU zero flag.
- uncond_br_i  in  1  unconditional PC-relative branch.
- reg_br_i  in  1  register branch (BR).
- imm_i  in  64  sign-extended word offset from the SEU.
- reg_target_i  in  64  register-branch target.
- fault_clr_i  in  1  acknowledge and clear a fault.
- pc_o  out  64  current PC.
- pc_next_o  out  64  combinational next-PC candidate.
- pc_valid_o  out  1  pc_o is a fetchable address.
- fault_o  out  1  misaligned target was detected.
- fault_addr_o  out  64  offending target address.
- taken_cnt_o  out  CNT_W  number of taken branches.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=BOOT, pc_o=RESET_VEC, pc_valid_o=0, fault_o=0, fault_addr_o=0, taken_cnt_o=0.
  - Reset may be asserted in any state and aborts the operation in progress immediately.
- Arithmetic (all modulo 2^64, wrap-around silently ignored, no overflow flag):
  - seq = pc_o + 4
  - rel = pc_o + (imm_i << 2)
- Target select, priority reg_br_i > uncond_br_i > (cond_br_i & zero_i) > sequential:
  - reg_br_i → reg_target_i
  - uncond_br_i → rel
  - cond_br_i & zero_i → rel
  - otherwise → seq
  - taken = any of the first three. pc_next_o shows the selected value combinationally in every state.
- States:
  - BOOT: one cycle with pc_valid_o=0, then → RUN. No PC update in this cycle.
  - RUN: pc_valid_o=1.
    - If en_i=0: hold everything.
    - Else, if the target has bits[1:0]≠0: PC holds, fault_addr_o←target, fault_o←1, → FAULT. The counter does not increment.
    - Else: pc_o←target; if taken, taken_cnt_o increments (wraps at 2^CNT_W−1 → 0). Then, if halt_i=1, → HALT.
    - halt_i together with a branch in the same cycle: the branch commits first, then → HALT.
    - halt_i while en_i=0: ignored.
  - HALT: pc_valid_o=0, PC frozen, branch inputs ignored. resume_i=1 → RUN next cycle; the PC is unchanged.
  - FAULT: pc_valid_o=0, PC frozen. fault_clr_i=1 → fault_o←0, → RUN, resuming at the held PC (fault_addr_o is retained). If resume_i and fault_clr_i are both asserted, fault_clr_i alone governs.
- Latency: a selected target appears on pc_o one clock after the deciding edge. There is no internal pipeline.
- Sequential (PC+4) targets are always aligned, so only branch targets can fault.

Decomposition:
- Shared package (cpu_pkg):
  - state enum: BOOT, RUN, HALT, FAULT
  - PC width constant 64
  - INSTR_BYTES=4
  - RESET_VEC default
- One natural sub-module, branch_target_gen. It is purely combinational: computes seq and rel and applies the priority mux. It replaces the standalone branch adder in the datapath. The top module holds the FSM, the PC register, the fault register and the counter.

Test Plan:
- Reset then idle run: release reset_n with en_i=1 and no branches → pc_valid_o=0 for one cycle, then pc_o = 0, 4, 8, 12 on successive edges; taken_cnt_o stays 0.
- Conditional branch: pc_o=0x100, cond_br_i=1, zero_i=1, imm_i=-2 → pc_o=0xF8 next cycle, taken_cnt_o=1.
  - Same cycle with zero_i=0 instead → pc_o=0x104, taken_cnt_o unchanged.
- Priority and wrap:
  - reg_br_i=1 and uncond_br_i=1 together, reg_target_i=0x2000 → pc_o=0x2000.
  - pc_o=0xFFFF_FFFF_FFFF_FFFC, sequential step → pc_o=0.
- Fault: reg_br_i=1, reg_target_i=0x1002 → fault_o=1, fault_addr_o=0x1002, pc_o unchanged, pc_valid_o=0.
  - Then fault_clr_i=1 → fault_o=0, RUN resumes at the old PC.
- Halt with branch: uncond_br_i=1, imm_i=3, halt_i=1 at pc_o=0x40 → pc_o=0x4C, HALT, pc_valid_o=0.
  - en_i stall cycles before the halt do not move the PC.
  - resume_i=1 → pc_valid_o=1 with pc_o=0x4C.
- Asynchronous reset mid-operation: assert reset_n=0 between clock edges while in FAULT with taken_cnt_o=5 → immediately pc_o=RESET_VEC, fault_o=0, taken_cnt_o=0, state BOOT.
